alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Sequencing controller that feeds the shared combinational `alu` from a byte-stream receiver and returns the result through a byte-stream transmitter. It sits between the UART RX/TX pair and the `alu` instance in the top level. It collects a three-byte frame (operand A, operand B, opcode) and holds the operands and opcode stable on the ALU inputs. It then registers the ALU result and hands it to the transmitter with a start/done handshake, aborting stale frames on timeout.

## Interface
- `NB_DATA`, 8, operand/result width; equals UART byte width
- `NB_OP`, 6, opcode width; taken from the low `NB_OP` bits of the opcode byte
- `TIMEOUT_CYCLES`, 100000, maximum idle cycles between bytes of one frame before abort

Ports:
- `i_clk` in 1: system clock; all logic on rising edge
- `i_rst_n` in 1: reset, asynchronous assert, active-low
- `i_rx_data` in NB_DATA: received byte, valid only while `i_rx_done`=1
- `i_rx_done` in 1: one-cycle pulse, byte available
- `i_tx_done` in 1: one-cycle pulse, transmitter finished the byte
- `o_tx_start` out 1: one-cycle pulse, start transmission of `o_tx_data`
- `o_tx_data` out NB_DATA: registered result byte
- `o_alu_data_A` out NB_DATA: registered operand A to ALU
- `o_alu_data_B` out NB_DATA: registered operand B to ALU
- `o_alu_op` out NB_OP: registered opcode to ALU
- `i_alu_result` in NB_DATA: ALU combinational result
- `o_error` out 1: one-cycle pulse on invalid opcode or timeout abort
- `o_busy` out 1: high in every state except `WAIT_A`

## Operation
- States:
  - `WAIT_A`, `WAIT_B`, `WAIT_OP`: collect the frame bytes in that order.
  - `EXEC`: ALU settles.
  - `WAIT_TX`: waits for the transmitter.
- `WAIT_A` + `i_rx_done`: latch `o_alu_data_A`, go to `WAIT_B`. `WAIT_B` + `i_rx_done`: latch `o_alu_data_B`, go to `WAIT_OP`.
- `WAIT_OP` + `i_rx_done`: check `i_rx_data[NB_OP-1:0]`. Valid opcodes are ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010. Upper byte bits are ignored.
  - Valid opcode: latch `o_alu_op`, go to `EXEC`.
  - Invalid opcode: `o_alu_op` unchanged, pulse `o_error`, go to `WAIT_A`, no transmission.
- `EXEC`: unconditional, register `i_alu_result` into `o_tx_data`, pulse `o_tx_start`, go to `WAIT_TX`.
- `WAIT_TX` + `i_tx_done`: go to `WAIT_A`. `i_rx_done` in `WAIT_TX` or `EXEC` is dropped (byte lost, no error).
- Timeout counter:
  - Cleared on every accepted byte and on entry to `WAIT_A`.
  - Counts only in `WAIT_B` and `WAIT_OP`.
  - When the count reaches `TIMEOUT_CYCLES-1` with no `i_rx_done`: pulse `o_error`, go to `WAIT_A`. Operand registers keep their values.
  - Width is $clog2(TIMEOUT_CYCLES).
- Simultaneous `i_rx_done` and timeout expiry in the same cycle: the byte wins, with no error.
- `WAIT_TX` has no timeout and waits indefinitely for `i_tx_done`.
- Arithmetic is performed entirely by the ALU; the controller never modifies data. All registers are NB_DATA or NB_OP wide, with no sign extension.

## Timing
- Reset (`i_rst_n`=0, any time including mid-frame or mid-TX): state `WAIT_A`, all outputs 0, timeout counter 0. Takes effect immediately and asynchronously.
- Op byte accepted at edge k: `o_alu_op` valid after k, state `EXEC` for cycle k..k+1.
- At edge k+1: `o_tx_data` = result, `o_tx_start`=1. At edge k+2: `o_tx_start`=0.
- Latency is 2 cycles from op-byte `i_rx_done` to `o_tx_start`.
- `o_tx_data` is stable from k+1 until the next `EXEC`.
- `o_alu_*` change only on byte-accept edges.
- `o_error` is high exactly one cycle, the cycle after the faulting edge.
- `o_busy` is registered from state, so it rises the cycle after operand A is accepted.
- Minimum frame-to-frame turnaround: next A byte is accepted on the cycle after `i_tx_done`.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `ADD_OP`, `SUB_OP`, `AND_OP`, `OR_OP`, `XOR_OP`, `NOR_OP`, `SRA_OP`, `SRL_OP`, also used by `alu`.
  - Function `is_valid_op`.
  - State encoding localparams (3-bit) for this controller.
- Sub-module `alu_frame_timer`: parameterised down-counter with `i_clear`, `i_enable`, `o_expired`.
- FSM, operand registers and handshake logic stay in `alu_uart_ctrl`.

## Test plan
- Frame 0x0A, 0x05, 0x20 with a real `alu` → one `o_tx_start` 2 cycles after the third `i_rx_done`, `o_tx_data`=0x0F, `o_error` never set.
- Frame 0xF0, 0x02, 0x03 (SRA) → `o_tx_data`=0xFC. Then frame 0x10, 0x02, 0xC2 (upper bits set, SRL) → `o_tx_data`=0x04.
- Frame 0x01, 0x02, 0x3F (invalid) → `o_error` pulse for one cycle, no `o_tx_start`, `o_busy`=0 next cycle, `o_alu_op` unchanged.
- `TIMEOUT_CYCLES`=16: send A only, wait 16 cycles → `o_error` pulse, state `WAIT_A`. Retry with a byte at exactly cycle 15 → no error.
- Extra byte 0x55 during `WAIT_TX`, `i_tx_done` delayed 50 cycles → byte ignored, single `o_tx_start`, next frame accepted normally.
- Assert `i_rst_n` low mid-`WAIT_OP` and again mid-`WAIT_TX` → all outputs 0 immediately, new frame after release processed correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode validity check and the
// state encoding of the UART-to-ALU sequencing controller.
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] ADD_OP = 6'b100000;
    localparam logic [OP_W-1:0] SUB_OP = 6'b100010;
    localparam logic [OP_W-1:0] AND_OP = 6'b100100;
    localparam logic [OP_W-1:0] OR_OP  = 6'b100101;
    localparam logic [OP_W-1:0] XOR_OP = 6'b100110;
    localparam logic [OP_W-1:0] NOR_OP = 6'b100111;
    localparam logic [OP_W-1:0] SRA_OP = 6'b000011;
    localparam logic [OP_W-1:0] SRL_OP = 6'b000010;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        EXEC    = ST_EXEC,
        WAIT_TX = ST_WAIT_TX
    } ctrl_state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        case (op)
            ADD_OP, SUB_OP, AND_OP, OR_OP,
            XOR_OP, NOR_OP, SRA_OP, SRL_OP: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_frame_timer.sv
// Inter-byte idle timer: reloads on clear, counts down while enabled and
// flags expiry once TIMEOUT_CYCLES-1 idle edges have elapsed.
module alu_frame_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The reload value stands for "zero cycles elapsed"; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = LOAD;
        end else if (i_enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_enable && (cnt_q == '0);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects an A/B/opcode byte frame from the UART receiver, drives the shared
// ALU with it and returns the registered result through the UART transmitter.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_alu_data_A,
    output logic [NB_DATA-1:0] o_alu_data_B,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_error,
    output logic               o_busy
);

    ctrl_state_t        state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;

    logic frame_active;
    logic byte_accept;
    logic timer_expired;

    assign frame_active = (state_q == WAIT_B) || (state_q == WAIT_OP);

    // Restarting the timer whenever no partial frame is pending covers entry to WAIT_A.
    alu_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (byte_accept || !frame_active),
        .i_enable (frame_active),
        .o_expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        error_d     = 1'b0;
        byte_accept = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    byte_accept = 1'b1;
                    a_d         = i_rx_data;
                    state_d     = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    byte_accept = 1'b1;
                    b_d         = i_rx_data;
                    state_d     = WAIT_OP;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                // A byte arriving on the expiry edge still completes the frame.
                if (i_rx_done) begin
                    byte_accept = 1'b1;
                    if (is_valid_op(i_rx_data[NB_OP-1:0])) begin
                        op_d    = i_rx_data[NB_OP-1:0];
                        state_d = EXEC;
                    end else begin
                        error_d = 1'b1;
                        state_d = WAIT_A;
                    end
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = WAIT_A;
                end
            end
            EXEC: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
        busy_d = (state_d != WAIT_A);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_alu_data_A = a_q;
    assign o_alu_data_B = b_q;
    assign o_alu_op     = op_q;
    assign o_error      = error_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized byte traffic.
module tb_alu_uart_ctrl;

    localparam int T = 16;

    localparam logic [5:0] VALID_OPS [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                             6'b100110, 6'b100111, 6'b000011, 6'b000010};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       error;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    int start_seen = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return $signed(a) >>> b;
            6'b000010: return a >> b;
            default:   return 8'h00;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU
    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    alu_uart_ctrl #(
        .NB_DATA       (8),
        .NB_OP         (6),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_tx_done   (tx_done),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_alu_data_A(alu_a),
        .o_alu_data_B(alu_b),
        .o_alu_op    (alu_op),
        .i_alu_result(alu_result),
        .o_error     (error),
        .o_busy      (busy)
    );

    // Reference model: phase = bytes collected (0..2), 3 = result pending, 4 = transmitting
    typedef struct {
        int         phase;
        int         idle;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] txd;
        logic       start;
        logic       err;
        logic       busy;
    } model_t;

    model_t m;

    function automatic bit op_ok(input logic [5:0] op);
        for (int i = 0; i < 8; i++) begin
            if (VALID_OPS[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.phase = 0; r.idle = 0; r.a = 8'h00; r.b = 8'h00; r.op = 6'h00;
        r.txd = 8'h00; r.start = 1'b0; r.err = 1'b0; r.busy = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t s, input logic rxd,
                                          input logic [7:0] rxb, input logic txd_done);
        model_t n = s;
        n.start = 1'b0;
        n.err   = 1'b0;
        if (s.phase == 0) begin
            if (rxd) begin n.a = rxb; n.phase = 1; n.idle = 0; end
        end else if (s.phase == 1 || s.phase == 2) begin
            if (rxd) begin
                n.idle = 0;
                if (s.phase == 1) begin
                    n.b = rxb; n.phase = 2;
                end else if (op_ok(rxb[5:0])) begin
                    n.op = rxb[5:0]; n.phase = 3;
                end else begin
                    n.err = 1'b1; n.phase = 0;
                end
            end else if (s.idle == T - 1) begin
                n.err = 1'b1; n.phase = 0; n.idle = 0;
            end else begin
                n.idle = s.idle + 1;
            end
        end else if (s.phase == 3) begin
            n.txd = alu_ref(s.a, s.b, s.op); n.start = 1'b1; n.phase = 4;
        end else begin
            if (txd_done) n.phase = 0;
        end
        n.busy = (n.phase != 0);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, rx_done, rx_data, tx_done);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("sb_tx_start", 32'(tx_start), 32'(m.start));
            check("sb_tx_data",  32'(tx_data),  32'(m.txd));
            check("sb_alu_a",    32'(alu_a),    32'(m.a));
            check("sb_alu_b",    32'(alu_b),    32'(m.b));
            check("sb_alu_op",   32'(alu_op),   32'(m.op));
            check("sb_error",    32'(error),    32'(m.err));
            check("sb_busy",     32'(busy),     32'(m.busy));
            if (tx_start === 1'b1) begin
                start_seen++;
                $display("tx: A=%02h B=%02h op=%02h -> %02h", alu_a, alu_b, alu_op, tx_data);
            end
            if (error === 1'b1) begin
                err_seen++;
                $display("error pulse at %0t", $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #2;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic ack_tx(input int delay);
        repeat (delay) @(posedge clk);
        #2 tx_done = 1'b1;
        @(posedge clk); #2;
        tx_done = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_start !== 1'b1 && n < 20);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp, input string name);
        int n;
        int e0;
        e0 = err_seen;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_start(n);
        check({name, "_latency"}, 32'(n), 32'd2);
        check({name, "_tx_data"}, 32'(tx_data), 32'(exp));
        ack_tx(1);
        check({name, "_no_error"}, 32'(err_seen - e0), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_start"}, 32'(tx_start), 32'd0);
        check({name, "_tx_data"},  32'(tx_data),  32'd0);
        check({name, "_alu_a"},    32'(alu_a),    32'd0);
        check({name, "_alu_b"},    32'(alu_b),    32'd0);
        check({name, "_alu_op"},   32'(alu_op),   32'd0);
        check({name, "_error"},    32'(error),    32'd0);
        check({name, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        int n;
        int s0;
        int e0;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        #1 rst_n = 1'b1;

        frame(8'h0A, 8'h05, 8'h20, 8'h0F, "add");
        frame(8'hF0, 8'h02, 8'h03, 8'hFC, "sra");
        frame(8'h10, 8'h02, 8'hC2, 8'h04, "srl_upper_bits");

        // Invalid opcode 0x3F
        s0 = start_seen;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h3F);
        @(negedge clk);
        check("inv_error",    32'(error),  32'd1);
        check("inv_busy",     32'(busy),   32'd0);
        check("inv_op_kept",  32'(alu_op), 32'h02);
        @(negedge clk);
        check("inv_error_one_cycle", 32'(error), 32'd0);
        repeat (5) @(posedge clk);
        #2 check("inv_no_tx", 32'(start_seen - s0), 32'd0);

        // Timeout: A only; 16 idle edges, error visible in the cycle after the 16th
        send_byte(8'h33);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (error !== 1'b1 && n < 40);
        check("timeout_cycles", 32'(n), 32'(T + 1));
        check("timeout_busy",   32'(busy), 32'd0);
        check("timeout_a_kept", 32'(alu_a), 32'h33);

        // B accepted 15 edges after A, opcode on the edge where the count hits T-1
        @(posedge clk); #2;
        e0 = err_seen;
        send_byte(8'h07);
        repeat (13) @(posedge clk);
        send_byte(8'h09);
        repeat (14) @(posedge clk);
        send_byte(8'h20);
        wait_start(n);
        check("late_latency", 32'(n), 32'd2);
        check("late_tx_data", 32'(tx_data), 32'h10);
        ack_tx(1);
        check("late_no_error", 32'(err_seen - e0), 32'd0);

        // Stray byte during WAIT_TX with a slow transmitter
        s0 = start_seen;
        e0 = err_seen;
        send_byte(8'h0C);
        send_byte(8'h03);
        send_byte(8'h22);
        wait_start(n);
        check("stray_tx_data", 32'(tx_data), 32'h09);
        send_byte(8'h55);
        ack_tx(50);
        check("stray_single_start", 32'(start_seen - s0), 32'd1);
        check("stray_no_error",     32'(err_seen - e0),   32'd0);
        frame(8'h21, 8'h0F, 8'h24, 8'h01, "after_stray");

        // Reset in WAIT_OP
        send_byte(8'h44);
        send_byte(8'h11);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_all_zero("rst_wait_op");
        @(posedge clk); #2 rst_n = 1'b1;
        frame(8'h44, 8'h11, 8'h26, 8'h55, "xor_after_rst");

        // Reset in WAIT_TX
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'h25);
        wait_start(n);
        check("or_tx_data", 32'(tx_data), 32'hFF);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_all_zero("rst_wait_tx");
        @(posedge clk); #2 rst_n = 1'b1;
        frame(8'h80, 8'h01, 8'h22, 8'h7F, "sub_after_rst");

        // Randomized traffic, with periodic quiet stretches longer than the timeout
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if ((i % 256) > 232) begin
                rx_done = 1'b0;
                tx_done = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) b = 8'($urandom);
                else b = {2'($urandom), VALID_OPS[$urandom_range(0, 7)]};
                rx_data = b;
                rx_done = ($urandom_range(0, 2) == 0);
                tx_done = ($urandom_range(0, 5) == 0);
            end
        end
        @(posedge clk); #2;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
